// File: rtl/sector_decode_fsm.sv
// RL02 read-path sector decoder: finds header/data sync in the MFM bit stream and packs fields into tagged words.
// Optional CRC-16 residue check over header and data fields when DECODE_CRC_EN is defined.
module sector_decode_fsm #(
    parameter int WORD_W     = 16,
    parameter int PRE_BITS   = 32,
    parameter int SYNC_TMO   = 64,
    parameter int HDR_WORDS  = 3,
    parameter int PO_BITS    = 16,
    parameter int DATA_WORDS = 129
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              bit_in_i,
    input  logic              bit_valid_i,
    input  logic              sector_pulse_i,
    input  logic              fifo_room_i,
    output logic [WORD_W:0]   word_out_o,
    output logic              word_ready_o,
    output logic              skip_mfm_bit_o,
    output logic              begin_write_o,
    output logic [2:0]        state_out_o,
    output logic              sector_done_o,
    output logic [2:0]        sector_stat_o,
    output logic [7:0]        sector_cnt_o
);
    localparam int CW  = $clog2(PRE_BITS + SYNC_TMO + WORD_W + PO_BITS);
    localparam int WCW = $clog2(HDR_WORDS + DATA_WORDS + 1);

    localparam logic [CW-1:0]  C_ONE     = CW'(1);
    localparam logic [CW-1:0]  PRE_N     = CW'(PRE_BITS);
    localparam logic [CW-1:0]  PRE_LAST  = CW'(PRE_BITS - 1);
    localparam logic [CW-1:0]  TMO_LAST  = CW'(PRE_BITS + SYNC_TMO - 1);
    localparam logic [CW-1:0]  WORD_LAST = CW'(WORD_W - 1);
    localparam logic [CW-1:0]  PO_LAST   = CW'(PO_BITS - 1);
    localparam logic [WCW-1:0] W_ONE     = WCW'(1);
    localparam logic [WCW-1:0] HDR_LAST  = WCW'(HDR_WORDS - 1);
    localparam logic [WCW-1:0] DATA_LAST = WCW'(DATA_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0, PRE_H = 3'd1, HDR = 3'd2, PO = 3'd3,
        GAP = 3'd4, PRE_D = 3'd5, DATA = 3'd6, DONE = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WCW-1:0]    wcnt_q, wcnt_d;
    logic [WORD_W-2:0] sh_q, sh_d;
    logic [WORD_W-1:0] sh_nx;
    logic [WORD_W:0]   word_q, word_d;
    logic              wr_q, wr_d, skip_q, skip_d, bw_q, bw_d, done_q, done_d;
    logic [2:0]        stat_q, stat_d;
    logic [7:0]        scnt_q, scnt_d;

`ifdef DECODE_CRC_EN
    logic [15:0] crc_q, crc_d, crc_nx;
    logic        crc_err_q, crc_err_d;
    // Reflected form of x^16+x^15+x^2+1 so an LSB-first appended CRC word leaves a zero residue
    assign crc_nx = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ bit_in_i) ? 16'hA001 : 16'h0000);
`endif

    assign sh_nx = {bit_in_i, sh_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        sh_d    = sh_q;
        word_d  = word_q;
        wr_d    = 1'b0;
        skip_d  = 1'b0;
        bw_d    = 1'b0;
        done_d  = 1'b0;
        stat_d  = 3'b000;
        scnt_d  = scnt_q;
`ifdef DECODE_CRC_EN
        crc_d     = crc_q;
        crc_err_d = crc_err_q;
`endif
        if (sector_pulse_i) begin
            state_d = PRE_H;
            cnt_d   = '0;
            wcnt_d  = '0;
            sh_d    = '0;
            word_d  = '0;
`ifdef DECODE_CRC_EN
            crc_d     = '0;
            crc_err_d = 1'b0;
`endif
        end else begin
            case (state_q)
                PRE_H, PRE_D: if (bit_valid_i) begin
                    if (cnt_q < PRE_N) begin
                        skip_d = (cnt_q == PRE_LAST) && bit_in_i;
                        cnt_d  = cnt_q + C_ONE;
                    end else if (bit_in_i) begin
                        cnt_d  = '0;
                        wcnt_d = '0;
`ifdef DECODE_CRC_EN
                        crc_d = '0;
`endif
                        if (state_q == PRE_H && !fifo_room_i) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            scnt_d  = scnt_q + 8'd1;
                            stat_d  = 3'b001;
                        end else begin
                            state_d = (state_q == PRE_H) ? HDR : DATA;
                        end
                    end else if (cnt_q == TMO_LAST) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        scnt_d  = scnt_q + 8'd1;
`ifdef DECODE_CRC_EN
                        stat_d = {crc_err_q, 2'b10};
`else
                        stat_d = 3'b010;
`endif
                    end else begin
                        cnt_d = cnt_q + C_ONE;
                    end
                end
                HDR, DATA: if (bit_valid_i) begin
                    sh_d = sh_nx[WORD_W-1:1];
`ifdef DECODE_CRC_EN
                    crc_d = crc_nx;
`endif
                    if (cnt_q == WORD_LAST) begin
                        cnt_d  = '0;
                        wr_d   = 1'b1;
                        word_d = {state_q == HDR, sh_nx};
                        wcnt_d = wcnt_q + W_ONE;
                        if (state_q == HDR && wcnt_q == HDR_LAST) begin
`ifdef DECODE_CRC_EN
                            crc_err_d = crc_err_q | (crc_nx != 16'h0000);
`endif
                            state_d = PO;
                        end else if (state_q == DATA && wcnt_q == DATA_LAST) begin
`ifdef DECODE_CRC_EN
                            crc_err_d = crc_err_q | (crc_nx != 16'h0000);
                            stat_d    = {crc_err_d, 2'b00};
`else
                            stat_d = 3'b000;
`endif
                            state_d = DONE;
                            done_d  = 1'b1;
                            scnt_d  = scnt_q + 8'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + C_ONE;
                    end
                end
                PO: if (bit_valid_i) begin
                    if (cnt_q == PO_LAST) begin
                        state_d = GAP;
                        bw_d    = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + C_ONE;
                    end
                end
                GAP: begin
                    state_d = PRE_D;
                    cnt_d   = '0;
                end
                default: ;  // IDLE and DONE wait for sector_pulse
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            sh_q    <= '0;
            word_q  <= '0;
            wr_q    <= 1'b0;
            skip_q  <= 1'b0;
            bw_q    <= 1'b0;
            done_q  <= 1'b0;
            stat_q  <= 3'b000;
            scnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            sh_q    <= sh_d;
            word_q  <= word_d;
            wr_q    <= wr_d;
            skip_q  <= skip_d;
            bw_q    <= bw_d;
            done_q  <= done_d;
            stat_q  <= stat_d;
            scnt_q  <= scnt_d;
        end
    end

`ifdef DECODE_CRC_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            crc_q     <= '0;
            crc_err_q <= 1'b0;
        end else begin
            crc_q     <= crc_d;
            crc_err_q <= crc_err_d;
        end
    end
`endif

    assign word_out_o     = word_q;
    assign word_ready_o   = wr_q;
    assign skip_mfm_bit_o = skip_q;
    assign begin_write_o  = bw_q;
    assign state_out_o    = state_q;
    assign sector_done_o  = done_q;
    assign sector_stat_o  = stat_q;
    assign sector_cnt_o   = scnt_q;
endmodule

// File: tb/tb_sector_decode_fsm.sv
// Randomized scoreboard bench for sector_decode_fsm: sector-level stimulus generator predicts
// the expected strobes (with their cycle) into a queue; a negedge monitor pops and compares.
module tb_sector_decode_fsm;
    logic        clk = 1'b0;
    logic        rst, bit_in, bit_valid, sector_pulse, fifo_room;
    logic [16:0] word_out;
    logic        word_ready, skip_mfm_bit, begin_write, sector_done;
    logic [2:0]  state_out, sector_stat;
    logic [7:0]  sector_cnt;

`ifdef DECODE_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    sector_decode_fsm dut (
        .clk_i(clk), .rst_i(rst), .bit_in_i(bit_in), .bit_valid_i(bit_valid),
        .sector_pulse_i(sector_pulse), .fifo_room_i(fifo_room),
        .word_out_o(word_out), .word_ready_o(word_ready), .skip_mfm_bit_o(skip_mfm_bit),
        .begin_write_o(begin_write), .state_out_o(state_out), .sector_done_o(sector_done),
        .sector_stat_o(sector_stat), .sector_cnt_o(sector_cnt)
    );

    always #5 clk = ~clk;

    // kind: 0 skip_mfm_bit, 1 word_ready, 2 begin_write, 3 sector_done
    typedef struct { int kind; logic [16:0] data; int cyc; } ev_t;
    ev_t q[$];
    int  cyc = 0;
    int  n_chk = 0, n_fail = 0;
    int  scnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic rb();
        return ($urandom_range(0, 1) == 1);
    endfunction

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [15:0] w);
        logic [15:0] r;
        r = c;
        for (int j = 0; j < 16; j++) begin
            logic fb;
            fb = r[0] ^ w[j];
            r = r >> 1;
            if (fb) r = r ^ 16'hA001;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [16:0] d, input int c);
        ev_t e;
        e.kind = k; e.data = d; e.cyc = c;
        q.push_back(e);
    endtask

    task automatic chk_ev(input int k, input logic [16:0] d);
        ev_t e;
        n_chk++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event kind=%0d data=%h cyc=%0d, expected nothing", k, d, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != k || e.data !== d || e.cyc != cyc) begin
                n_fail++;
                $display("FAIL event: got kind=%0d data=%h cyc=%0d, expected kind=%0d data=%h cyc=%0d",
                         k, d, cyc, e.kind, e.data, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            n_chk++;
            n_fail++;
            $display("FAIL missing_event: got none, expected kind=%0d data=%h at cyc=%0d", q[0].kind, q[0].data, q[0].cyc);
            q.delete(0);
        end
        if (skip_mfm_bit) chk_ev(0, 17'd0);
        if (word_ready)   chk_ev(1, word_out);
        if (begin_write)  chk_ev(2, 17'd0);
        if (sector_done) begin
            chk_ev(3, {6'd0, sector_stat, sector_cnt});
            chk("done_state", 32'(state_out), 32'd7);
        end
    end

    task automatic step(input logic bv, input logic b, input logic sp, input logic fr);
        bit_valid = bv; bit_in = b; sector_pulse = sp; fifo_room = fr;
        @(posedge clk); #1;
        bit_valid = 1'b0; sector_pulse = 1'b0;
    endtask

    // c returns the cycle in which the bit was presented; its effects show at c+1
    task automatic send_bit(input logic b, input logic fr, output int c);
        if ($urandom_range(0, 3) == 0) step(1'b0, rb(), 1'b0, rb());
        c = cyc;
        step(1'b1, b, 1'b0, fr);
    endtask

    task automatic exp_done(input logic [2:0] st, input int c);
        scnt = (scnt + 1) % 256;
        push(3, {6'd0, st, 8'(scnt)}, c + 1);
    endtask

    task automatic preamble(input bit hdr, input int mode, output bit ok);
        int c, z;
        logic b;
        ok = 1'b0;
        for (int i = 0; i < 32; i++) begin
            b = rb();
            send_bit(b, rb(), c);
            if (i == 31 && b) push(0, 17'd0, c + 1);
        end
        if ((hdr && mode == 2) || (!hdr && mode == 3)) begin
            for (int i = 0; i < 64; i++) send_bit(1'b0, rb(), c);
            exp_done(3'b010, c);
            return;
        end
        z = $urandom_range(0, 63);
        for (int i = 0; i < z; i++) send_bit(1'b0, rb(), c);
        if (hdr && mode == 1) begin
            send_bit(1'b1, 1'b0, c);
            exp_done(3'b001, c);
        end else begin
            send_bit(1'b1, hdr ? 1'b1 : rb(), c);
            ok = 1'b1;
        end
    endtask

    task automatic field(input bit hdr, input int n, input int abort_at, input bit flip,
                         input bit fixed, output bit ok, output int c);
        logic [15:0] w[$];
        logic [15:0] crc, wd;
        int sent;
        crc = 16'h0000; sent = 0; ok = 1'b0; c = cyc;
        for (int i = 0; i < n - 1; i++) begin
            wd = (fixed && i == 0) ? 16'h1234 : (fixed && i == 1) ? 16'h0000 : 16'($urandom);
            w.push_back(wd);
            crc = crc_upd(crc, wd);
        end
        w.push_back(crc);
        if (flip) begin
            int k;
            k = $urandom_range(0, n - 1);
            w[k] = w[k] ^ (16'h0001 << $urandom_range(0, 15));
        end
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 16; j++) begin
                if (sent == abort_at) return;
                send_bit(w[i][j], rb(), c);
                sent++;
                if (j == 15) push(1, {hdr, w[i]}, c + 1);
            end
        end
        ok = 1'b1;
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_outs"}, 32'({word_out, word_ready, skip_mfm_bit, begin_write, sector_done, sector_stat}), 32'd0);
        chk({tag, "_state"}, 32'(state_out), 32'd0);
        chk({tag, "_cnt"}, 32'(sector_cnt), 32'd0);
    endtask

    // modes: 0 nominal, 1 no fifo room, 2 header sync timeout, 3 data sync timeout,
    // 4 restart mid-header, 5 restart mid-data, 6 corrupted data bit, 7 reset mid-data
    task automatic sector(input int mode, input bit fixed);
        bit ok;
        int c;
        step(rb(), rb(), 1'b1, rb());
        preamble(1'b1, mode, ok);
        if (ok) begin
            field(1'b1, 3, (mode == 4) ? $urandom_range(0, 47) : -1, 1'b0, fixed, ok, c);
            if (!ok) return;
            for (int i = 0; i < 16; i++) begin
                send_bit(rb(), rb(), c);
                if (i == 15) push(2, 17'd0, c + 1);
            end
            step(1'b0, rb(), 1'b0, rb());
            preamble(1'b0, mode, ok);
        end
        if (ok) begin
            field(1'b0, 129, (mode == 5 || mode == 7) ? $urandom_range(0, 2063) : -1,
                  mode == 6, 1'b0, ok, c);
            if (mode == 7) begin
                rst = 1'b1;
                step(rb(), rb(), rb(), rb());
                rst = 1'b0;
                scnt = 0;
                check_reset_outs("reset_mid");
                return;
            end
            if (!ok) return;
            exp_done({CRC_ON && mode == 6, 2'b00}, c);
        end
        for (int i = 0; i < 4; i++) send_bit(rb(), rb(), c);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int modes[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
        rst = 1'b1; sector_pulse = 1'b1; bit_valid = 1'b1; bit_in = 1'b1; fifo_room = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outs("reset");
        rst = 1'b0; sector_pulse = 1'b0; bit_valid = 1'b0;
        for (int i = 0; i < 3; i++) send_bit(rb(), rb(), c);
        for (int i = 0; i < 9; i++) sector(modes[i], i == 0);
        for (int i = 0; i < 4; i++) sector($urandom_range(0, 6), 1'b0);
        sector(0, 1'b0);
        repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
